chunk_addsub: RTL
=================

CHUNK_ADDSUB -- requirements
Module: chunk_addsub

Interface
REQ-001 SHALL have parameter N, default 16, operand/result width in bits.
REQ-002 SHALL have parameter K, default 4, slice width in bits; N SHALL be a nonzero multiple of K, and M = N/K is the slice count.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  operation request, sampled on the rising edge.
REQ-006 SHALL have port sub  input  1  0 = add, 1 = subtract; sampled with start.
REQ-007 SHALL have ports x, y  input  N each  operands; sampled with start.
REQ-008 SHALL have port carryin  input  1  carry-in (add) or borrow-in (subtract); sampled with start.
REQ-009 SHALL have port busy  output  1  high while slices are being processed.
REQ-010 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-011 SHALL have port sum  output  N  registered result.
REQ-012 SHALL have port carryout  output  1  raw carry out of the MSB slice.
REQ-013 SHALL have port overflow  output  1  signed two's-complement overflow flag.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 SHALL accept start only when busy=0, i.e. in IDLE or DONE.
  - On acceptance: latch x; latch y, or ~y when sub=1; latch the initial carry as carryin, or ~carryin when sub=1; clear the slice index; go to RUN.
REQ-016 SHALL ignore start while in RUN, with no effect on the operation in progress.
REQ-017 SHALL add exactly one K-bit slice per RUN cycle, LSB slice first, propagating the carry registered from the previous slice.
REQ-018 SHALL transition RUN -> DONE after slice M-1; DONE -> IDLE after one cycle unless start is accepted, in which case DONE -> RUN.
REQ-019 Timing: if start is accepted at edge 0, busy SHALL be high during cycles 1..M and done SHALL be high during cycle M+1 only.
REQ-020 SHALL produce sum = x + y + carryin (mod 2^N) for add.
REQ-021 SHALL produce sum = x - y - carryin (mod 2^N) for subtract; carryout=1 there means no borrow.
REQ-022 SHALL compute overflow = (carry into bit N-1) XOR (carry out of bit N-1).
REQ-023 SHALL update sum, carryout and overflow only at the edge entering DONE, and hold them until the next operation completes; partial results SHALL never appear on sum.
REQ-024 Boundary: M=1 (K=N) SHALL give busy for exactly one cycle and done in cycle 2.

Reset
REQ-025 On rst_n=0, SHALL immediately force the FSM to IDLE and busy, done, sum, carryout, overflow and all working registers to 0, regardless of clock.
REQ-026 Reset mid-operation SHALL abort the operation with no done pulse; the first start accepted after rst_n rises SHALL behave as from power-up.

Configuration
REQ-027 SATURATE_EN defined: when overflow=1, sum SHALL clamp to 2^(N-1)-1 if the true result is positive (operand sign bit 0) or to 2^(N-1) if negative; carryout and overflow are unchanged.
REQ-028 SATURATE_EN undefined: sum SHALL wrap modulo 2^N; no clamp logic SHALL be present.

Verification (N=16, K=4)
REQ-029 Add 0x7FFF + 0x0001, carryin=0 -> done in cycle 5, sum=0x8000 (0x7FFF with SATURATE_EN), carryout=0, overflow=1.
REQ-030 Add 0xFFFF + 0x0001, carryin=0 -> sum=0x0000, carryout=1, overflow=0.
REQ-031 Subtract 0x0005 - 0x0007, carryin=0 -> sum=0xFFFE, carryout=0, overflow=0; subtract 0x8000 - 0x0001 -> overflow=1, sum=0x7FFF (0x8000 with SATURATE_EN).
REQ-032 Start in cycle 2 of an operation with different operands -> ignored; the original result appears in cycle 5; back-to-back start during done cycle accepted, next done in cycle 10.
REQ-033 rst_n pulsed low in cycle 3 -> all outputs 0 asynchronously, no done; a new add 0x1234 + 0x1111 -> sum=0x2345 five cycles after its start.

Source files
------------

// File: rtl/chunk_addsub.sv
`timescale 1ns/1ps
// chunk_addsub: multi-cycle N-bit adder/subtractor that processes one K-bit slice per clock.
// Latency: start accepted at edge 0 -> busy in cycles 1..M, done pulse in cycle M+1 (M = N/K).
// Backpressure: start is ignored while busy; a start in the done cycle is accepted back-to-back.
// Optional feature: define SATURATE_EN to clamp the result on signed overflow (default: wrap).
module chunk_addsub #(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         carryin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         carryout,
    output logic         overflow
);

    localparam int M  = N / K;
    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam logic [IW-1:0] LAST = IW'(M - 1);

    // Reject configurations that cannot be cut into whole slices.
    if (K < 1 || N < 1 || (N % K) != 0) begin : g_bad_cfg
        $error("chunk_addsub: N must be a nonzero multiple of K");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  a_reg;     // latched x
    logic [N-1:0]  b_reg;     // latched y, inverted for subtract
    logic [N-1:0]  acc;       // slices completed so far (never visible on sum)
    logic          c_reg;     // carry out of the previous slice
    logic [IW-1:0] idx;       // slice currently being added

    int            base;
    logic [K-1:0]  a_sl;
    logic [K-1:0]  b_sl;
    logic [K:0]    slice_full;
    logic          msb_cin;
    logic          ovf_next;
    logic [N-1:0]  full_res;
    logic [N-1:0]  res_out;
    logic          accept;

    // Start is honoured only when no operation is in flight.
    assign accept = start && (state != RUN);

    // Slice adder plus final-result assembly and overflow detection for the last slice.
    always_comb begin
        base       = int'(idx) * K;
        a_sl       = a_reg[base +: K];
        b_sl       = b_reg[base +: K];
        slice_full = {1'b0, a_sl} + {1'b0, b_sl} + {{K{1'b0}}, c_reg};
        // Carry into the slice MSB recovered from the sum bit, so K=1 needs no special case.
        msb_cin    = slice_full[K-1] ^ a_sl[K-1] ^ b_sl[K-1];
        ovf_next   = msb_cin ^ slice_full[K];
        full_res   = acc;
        full_res[base +: K] = slice_full[K-1:0];
        res_out    = full_res;
`ifdef SATURATE_EN
        // On overflow both effective operands share x's sign, which is the sign of the true result.
        if (ovf_next) begin
            res_out = a_reg[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
`else
        // Wrapping build: the modulo-2^N result is used as-is.
`endif
    end

    // Control FSM with working registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            c_reg    <= 1'b0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        // Subtract is x + ~y + ~borrow_in.
                        a_reg <= x;
                        b_reg <= sub ? ~y : y;
                        c_reg <= sub ? ~carryin : carryin;
                        acc   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc[base +: K] <= slice_full[K-1:0];
                    c_reg          <= slice_full[K];
                    idx            <= idx + 1'b1;
                    if (idx == LAST) begin
                        // Results are published only here, never mid-operation.
                        sum      <= res_out;
                        carryout <= slice_full[K];
                        overflow <= ovf_next;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
